// File: rtl/demux16_rr_sched.sv
// Round-robin scheduler driving the select/enable of a shared 1-to-16 demux.
// Define SCHED_FIXED_PRIO_EN for fixed priority (lowest eligible index always wins).
module demux16_rr_sched #(
  parameter int unsigned DWELL = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] req,
  input  logic [15:0] mask,
  output logic [3:0]  s,
  output logic        e,
  output logic [15:0] gnt,
  output logic        busy
);

  localparam int unsigned CW = $clog2(DWELL) + 1;

  typedef enum logic [1:0] {IDLE, GRANT, GUARD} state_t;

  state_t        state_q, state_nxt;
  logic [CW-1:0] cnt_q, cnt_nxt;
  logic [3:0]    ptr_q, s_nxt, pick, idx;
  logic [15:0]   gnt_nxt, elig;
  logic          e_nxt, found, release_grant;

`ifdef SCHED_FIXED_PRIO_EN
  assign ptr_q = '0;
`else
  logic [3:0] ptr_nxt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s       <= '0;
      e       <= 1'b1;
      gnt     <= '0;
      cnt_q   <= '0;
`ifndef SCHED_FIXED_PRIO_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_nxt;
      s       <= s_nxt;
      e       <= e_nxt;
      gnt     <= gnt_nxt;
      cnt_q   <= cnt_nxt;
`ifndef SCHED_FIXED_PRIO_EN
      ptr_q   <= ptr_nxt;
`endif
    end
  end

  // Arbitration search and next-state selection.
  always_comb begin
    elig  = en ? (req & ~mask) : '0;
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      idx = ptr_q + i[3:0];
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    release_grant = (cnt_q == '0) || !req[s] || mask[s] || !en;
    state_nxt = state_q;
    unique case (state_q)
      IDLE, GUARD: state_nxt = found ? GRANT : IDLE;
      GRANT:       if (release_grant) state_nxt = GUARD;
      default:     state_nxt = IDLE;
    endcase
  end

  // Next values for the registered demux controls; s never moves while in GRANT.
  always_comb begin
    s_nxt   = s;
    e_nxt   = e;
    gnt_nxt = gnt;
    cnt_nxt = cnt_q;
`ifndef SCHED_FIXED_PRIO_EN
    ptr_nxt = ptr_q;
`endif
    unique case (state_q)
      IDLE, GUARD: begin
        if (found) begin
          s_nxt   = pick;
          e_nxt   = 1'b0;
          gnt_nxt = 16'(1) << pick;
          cnt_nxt = CW'(DWELL - 1);
        end else begin
          e_nxt   = 1'b1;
          gnt_nxt = '0;
        end
      end
      GRANT: begin
        if (release_grant) begin
          e_nxt   = 1'b1;
          gnt_nxt = '0;
`ifndef SCHED_FIXED_PRIO_EN
          ptr_nxt = s + 4'd1;
`endif
        end else begin
          cnt_nxt = cnt_q - CW'(1);
        end
      end
      default: begin
        e_nxt   = 1'b1;
        gnt_nxt = '0;
      end
    endcase
    busy = (state_q != IDLE);
  end

endmodule

// File: tb/tb_demux16_rr_sched.sv
// Directed bench for demux16_rr_sched (DWELL=4); expectations follow SCHED_FIXED_PRIO_EN.
module tb_demux16_rr_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic [15:0] req = '0;
  logic [15:0] mask = '0;
  logic [3:0]  s;
  logic        e;
  logic [15:0] gnt;
  logic        busy;

  int tests = 0;
  int fails = 0;

  demux16_rr_sched #(.DWELL(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .req  (req),
    .mask (mask),
    .s    (s),
    .e    (e),
    .gnt  (gnt),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // gnt is expected to be one-hot on s only while the demux is enabled.
  task automatic expect_out(input string tag, input logic [3:0] es, input logic ee, input logic eb);
    logic [15:0] eg;
    eg = ee ? 16'h0000 : (16'h0001 << es);
    chk({tag, ".s"},    32'(s),    32'(es));
    chk({tag, ".e"},    32'(e),    32'(ee));
    chk({tag, ".gnt"},  32'(gnt),  32'(eg));
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; mask = '0; en = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [3:0] rot_seq [5];
  logic [3:0] late_first;

  initial begin
`ifdef SCHED_FIXED_PRIO_EN
    rot_seq = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    late_first = 4'd3;
`else
    rot_seq = '{4'd0, 4'd4, 4'd15, 4'd0, 4'd4};
    late_first = 4'd4;
`endif

    // Reset held with every channel requesting
    rst = 1'b1; en = 1'b1; req = 16'hFFFF; mask = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("reset", 4'd0, 1'b1, 1'b0);
    end
    rst = 1'b0;
    tick();
    expect_out("first_grant", 4'd0, 1'b0, 1'b1);

    // Sole requester: 4 grant cycles, 1 guard, repeat
    do_reset();
    req = 16'h0020;
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        expect_out("single_grant", 4'd5, 1'b0, 1'b1);
      end
      tick();
      expect_out("single_guard", 4'd5, 1'b1, 1'b1);
    end
    tick();
    expect_out("single_regrant", 4'd5, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    expect_out("reset_midgrant", 4'd0, 1'b1, 1'b0);

    // Rotation with wrap from 15 back to 0
    do_reset();
    req = 16'h8011;
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        expect_out("rot_grant", rot_seq[g], 1'b0, 1'b1);
      end
      tick();
      expect_out("rot_guard", rot_seq[g], 1'b1, 1'b1);
    end

    // Early release by dropping the request
    do_reset();
    req = 16'h0008;
    tick();
    expect_out("early_g1", 4'd3, 1'b0, 1'b1);
    tick();
    expect_out("early_g2", 4'd3, 1'b0, 1'b1);
    req = '0;
    tick();
    expect_out("early_guard", 4'd3, 1'b1, 1'b1);
    tick();
    expect_out("early_idle", 4'd3, 1'b1, 1'b0);
    tick();
    expect_out("early_idle2", 4'd3, 1'b1, 1'b0);
    req = 16'h0018;
    tick();
    expect_out("early_ptr", late_first, 1'b0, 1'b1);

    // Mask excludes channel 0, then enable drops mid-grant
    do_reset();
    req = 16'h0003; mask = 16'h0001;
    tick();
    expect_out("mask_g1", 4'd1, 1'b0, 1'b1);
    tick();
    expect_out("mask_g2", 4'd1, 1'b0, 1'b1);
    en = 1'b0;
    tick();
    expect_out("en_guard", 4'd1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("en_idle", 4'd1, 1'b1, 1'b0);
    end

    // Mask asserted on the granted channel releases it
    do_reset();
    req = 16'h0004;
    tick();
    expect_out("maskrel_g", 4'd2, 1'b0, 1'b1);
    mask = 16'h0004;
    tick();
    expect_out("maskrel_guard", 4'd2, 1'b1, 1'b1);
    tick();
    expect_out("maskrel_idle", 4'd2, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
